multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised multicycle control unit for the RISC-V core: a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles, driving the shared-ALU/shared-memory datapath. It supersedes the single-cycle main decoder. It adds a memory ready handshake with a bus-timeout watchdog, a retired-instruction counter, and optional illegal-opcode trapping. It sits between the instruction register (opcode input) and the datapath mux/enable controls.

## Interface
- `MAX_WAIT`, default 8: cycles a memory state may wait for `mem_ready` before bus error; must be ≥1.
- `WAIT_W`, default 4: wait-counter width; must satisfy 2^WAIT_W > MAX_WAIT.
- `CNT_W`, default 32: retired-instruction counter width.
- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `op` input 7: opcode of the current instruction register.
- `mem_ready` input 1: memory completes the current access this cycle.
- `trap_ack` input 1: trap handler acknowledge; used only with the trap feature.
- `mem_req` output 1: memory access request.
- `adrsrc` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `irwrite`, `pcupdate`, `memwrite`, `regwrite`, `branch` outputs, 1 bit each: datapath enables.
- `alusrca`, `alusrcb`, `aluop`, `resultsrc` outputs, 2 bits each: datapath selects.
- `immsrc` output 3: I=000, S=001, B=010, J=011, U=100.
- `bus_err` output 1: sticky bus-timeout flag.
- `illegal_instr` output 1: trap pending.
- `instret` output CNT_W: retired-instruction count.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, UPPER, TRAP, ERR.
- Outputs are decoded from state only, except `irwrite` and `pcupdate` in FETCH, which are qualified by `mem_ready`. Unlisted outputs are 0.
- FETCH: `mem_req`=1, `adrsrc`=0, `alusrca`=00, `alusrcb`=10, `aluop`=00, `resultsrc`=10, `irwrite`=`pcupdate`=`mem_ready`. Leaves for DECODE on `mem_ready`.
- DECODE: `alusrca`=01, `alusrcb`=01, `aluop`=00. Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 or 0010111 → UPPER
  - any other → TRAP or FETCH (see Configuration)
- MEMADR: `alusrca`=10, `alusrcb`=01. Next is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: `mem_req`=1, `adrsrc`=1. Goes to MEMWB on `mem_ready`.
- MEMWB: `resultsrc`=01, `regwrite`=1. Then FETCH.
- MEMWRITE: `mem_req`=1, `adrsrc`=1, `memwrite`=1. Goes to FETCH on `mem_ready`.
- EXECR: `alusrca`=10, `alusrcb`=00, `aluop`=10. Then ALUWB.
- EXECI: as EXECR but `alusrcb`=01. Then ALUWB.
- ALUWB: `resultsrc`=00, `regwrite`=1. Then FETCH.
- BRANCH: `alusrca`=10, `alusrcb`=00, `aluop`=01, `branch`=1. Then FETCH.
- JAL: `alusrca`=01, `alusrcb`=10, `resultsrc`=00, `pcupdate`=1. Then ALUWB.
- UPPER: `regwrite`=1; `resultsrc`=11 for lui, 00 for auipc. Then FETCH.
- `immsrc` is decoded combinationally from `op` in every state; unknown opcodes give 000.
- Wait counter: cleared on entry to any memory state and whenever `mem_ready`=1. Increments each cycle a memory state holds without ready. If it reaches MAX_WAIT, the next state is ERR.
- ERR: all enables and `mem_req` are 0; `bus_err`=1. Exits only by reset.
- `instret` increments by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or UPPER, and from DECODE when an illegal opcode is treated as a NOP. Transitions from TRAP do not count.
- Reset (asynchronous, `rst_n`=0): state=FETCH, counters=0, `bus_err`=0. All outputs are forced to 0 while `rst_n` is low. A reset mid-access abandons the access with no write committed by this block.

## Timing
- Cycles per instruction with zero-wait memory: R/I-ALU 4, load 5, store 4, branch 3, jal 4, lui/auipc 3.
- Each cycle `mem_ready` is low in a memory state adds one cycle.
- `bus_err` rises the cycle after the MAX_WAIT-th consecutive not-ready cycle. With MAX_WAIT=8, that is cycle 9 of a stalled FETCH.
- `mem_ready` outside a memory state is ignored.

## Configuration
- `MULTICYCLE_TRAP_EN` defined:
  - An unknown opcode in DECODE → TRAP.
  - In TRAP, `illegal_instr`=1 and all enables are 0.
  - When `trap_ack`=1, the next state is FETCH and `instret` is not incremented.
- `MULTICYCLE_TRAP_EN` undefined:
  - An unknown opcode in DECODE → FETCH and counts as retired (NOP).
  - TRAP is unreachable, `illegal_instr` is tied 0, and `trap_ack` is ignored.

## Test plan
- Reset, `mem_ready`=1, `op`=0110011 → states FETCH, DECODE, EXECR, ALUWB, FETCH. `regwrite`=1 only in the 4th cycle. `instret`=1 after the 4th cycle.
- Load with `mem_ready` low for 3 cycles in MEMREAD → 8 cycles total, `regwrite` pulses once in MEMWB, `bus_err`=0.
- FETCH with `mem_ready` held 0, MAX_WAIT=8 → `bus_err`=1 on cycle 9, stays 1 with any `mem_ready`, and clears only on `rst_n`=0.
- `op`=1111111 with the macro defined → TRAP with `illegal_instr`=1; `trap_ack` pulse → FETCH, `instret` unchanged. Without the macro → FETCH, `instret`+1.
- CNT_W=4 with 16 consecutive branches → `instret` wraps to 0. `rst_n` pulsed low mid-MEMWRITE → outputs are 0 immediately; after release, state is FETCH and `instret`=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: fetch/decode/execute/memory/writeback sequencing with a
// mem_ready watchdog and retired-instruction counter. Optional trapping: MULTICYCLE_TRAP_EN.
module multicycle_ctrl #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    input  logic             trap_ack,
    output logic             mem_req,
    output logic             adrsrc,
    output logic             irwrite,
    output logic             pcupdate,
    output logic             memwrite,
    output logic             regwrite,
    output logic             branch,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       resultsrc,
    output logic [2:0]       immsrc,
    output logic             bus_err,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_UPPER    = 4'd11,
        S_TRAP     = 4'd12,
        S_ERR      = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_instret;
    logic              w_is_mem;
    logic              w_timeout;
    logic              w_illegal;
    logic              w_retire;

    logic       w_mem_req, w_adrsrc, w_irwrite, w_pcupdate, w_memwrite;
    logic       w_regwrite, w_branch, w_bus_err, w_illegal_instr;
    logic [1:0] w_alusrca, w_alusrcb, w_aluop, w_resultsrc;
    logic [2:0] w_immsrc;

    assign w_is_mem  = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    // Counter holds the number of not-ready cycles already spent; this cycle is the MAX_WAIT-th.
    assign w_timeout = w_is_mem && !mem_ready && (r_wait == WAIT_W'(MAX_WAIT - 1));

    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECR;
                    OP_I:              w_next = S_EXECI;
                    OP_BR:             w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_LUI, OP_AUIPC:  w_next = S_UPPER;
                    default: begin
                        w_illegal = 1'b1;
`ifdef MULTICYCLE_TRAP_EN
                        w_next    = S_TRAP;
`else
                        w_next    = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR:   w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_UPPER:    w_next = S_FETCH;
`ifdef MULTICYCLE_TRAP_EN
            S_TRAP:     if (trap_ack) w_next = S_FETCH;
`endif
            S_ERR:      w_next = S_ERR;
            default:    w_next = S_FETCH;
        endcase
        if (w_timeout) w_next = S_ERR;
    end

    // A trap return to FETCH is deliberately excluded from the retire set.
    assign w_retire = (w_next == S_FETCH) &&
                      ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) || (r_state == S_ALUWB) ||
                       (r_state == S_BRANCH) || (r_state == S_UPPER) ||
                       ((r_state == S_DECODE) && w_illegal));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_is_mem && !mem_ready) r_wait <= r_wait + WAIT_W'(1);
            else                        r_wait <= '0;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

    always_comb begin
        w_mem_req       = 1'b0;
        w_adrsrc        = 1'b0;
        w_irwrite       = 1'b0;
        w_pcupdate      = 1'b0;
        w_memwrite      = 1'b0;
        w_regwrite      = 1'b0;
        w_branch        = 1'b0;
        w_alusrca       = 2'b00;
        w_alusrcb       = 2'b00;
        w_aluop         = 2'b00;
        w_resultsrc     = 2'b00;
        w_bus_err       = 1'b0;
        w_illegal_instr = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_irwrite   = mem_ready;
                w_pcupdate  = mem_ready;
            end
            S_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adrsrc  = 1'b1;
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                w_mem_req  = 1'b1;
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECR: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b10;
            end
            S_EXECI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluop   = 2'b10;
            end
            S_ALUWB:  w_regwrite = 1'b1;
            S_BRANCH: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b01;
                w_branch  = 1'b1;
            end
            S_JAL: begin
                w_alusrca  = 2'b01;
                w_alusrcb  = 2'b10;
                w_pcupdate = 1'b1;
            end
            S_UPPER: begin
                w_regwrite  = 1'b1;
                w_resultsrc = (op == OP_LUI) ? 2'b11 : 2'b00;
            end
`ifdef MULTICYCLE_TRAP_EN
            S_TRAP:   w_illegal_instr = 1'b1;
`endif
            S_ERR:    w_bus_err = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:         w_immsrc = 3'b001;
            OP_BR:            w_immsrc = 3'b010;
            OP_JAL:           w_immsrc = 3'b011;
            OP_LUI, OP_AUIPC: w_immsrc = 3'b100;
            default:          w_immsrc = 3'b000;
        endcase
    end

`ifndef MULTICYCLE_TRAP_EN
    logic w_unused_trap_ack;
    assign w_unused_trap_ack = trap_ack;
`endif

    // Reset is asynchronous, so every output is gated directly by rst_n rather than by state.
    always_comb begin
        mem_req       = 1'b0;
        adrsrc        = 1'b0;
        irwrite       = 1'b0;
        pcupdate      = 1'b0;
        memwrite      = 1'b0;
        regwrite      = 1'b0;
        branch        = 1'b0;
        alusrca       = 2'b00;
        alusrcb       = 2'b00;
        aluop         = 2'b00;
        resultsrc     = 2'b00;
        immsrc        = 3'b000;
        bus_err       = 1'b0;
        illegal_instr = 1'b0;
        instret       = '0;
        dbg_state     = 4'd0;
        if (rst_n) begin
            mem_req       = w_mem_req;
            adrsrc        = w_adrsrc;
            irwrite       = w_irwrite;
            pcupdate      = w_pcupdate;
            memwrite      = w_memwrite;
            regwrite      = w_regwrite;
            branch        = w_branch;
            alusrca       = w_alusrca;
            alusrcb       = w_alusrcb;
            aluop         = w_aluop;
            resultsrc     = w_resultsrc;
            immsrc        = w_immsrc;
            bus_err       = w_bus_err;
            illegal_instr = w_illegal_instr;
            instret       = r_instret;
            dbg_state     = r_state;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control vectors go through a queue
// and are compared at the falling edge. Honours MULTICYCLE_TRAP_EN for the illegal-opcode case.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;
    localparam int W     = 24 + CNT_W;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_UPPER    = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;
    localparam logic [3:0] S_ERR      = 4'd13;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [6:0]       op;
    logic             mem_ready, trap_ack;
    logic             mem_req, adrsrc, irwrite, pcupdate, memwrite, regwrite, branch;
    logic [1:0]       alusrca, alusrcb, aluop, resultsrc;
    logic [2:0]       immsrc;
    logic             bus_err, illegal_instr;
    logic [CNT_W-1:0] instret;
    logic [3:0]       dbg_state;

    multicycle_ctrl #(.MAX_WAIT(8), .WAIT_W(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready), .trap_ack(trap_ack),
        .mem_req(mem_req), .adrsrc(adrsrc), .irwrite(irwrite), .pcupdate(pcupdate),
        .memwrite(memwrite), .regwrite(regwrite), .branch(branch),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .resultsrc(resultsrc),
        .immsrc(immsrc), .bus_err(bus_err), .illegal_instr(illegal_instr),
        .instret(instret), .dbg_state(dbg_state)
    );

    logic [W-1:0] w_obs;
    assign w_obs = {dbg_state, mem_req, adrsrc, irwrite, pcupdate, memwrite, regwrite, branch,
                    alusrca, alusrcb, aluop, resultsrc, immsrc, bus_err, illegal_instr, instret};

    // scoreboard
    logic [W-1:0]     exp_q[$];
    logic [CNT_W-1:0] exp_instret;
    int               n_cmp  = 0;
    int               n_fail = 0;
    string            tag;

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [W-1:0] exp_vec(input logic [3:0] st, input logic [6:0] o, input logic mr);
        logic       mreq, asrc, irw, pcu, mw, rw, br, be, ill;
        logic [1:0] sa, sb, aop, rs;
        logic [2:0] imm;
        {mreq, asrc, irw, pcu, mw, rw, br, be, ill} = '0;
        {sa, sb, aop, rs} = '0;
        case (st)
            S_FETCH:    begin mreq = 1'b1; sb = 2'b10; rs = 2'b10; irw = mr; pcu = mr; end
            S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            S_MEMREAD:  begin mreq = 1'b1; asrc = 1'b1; end
            S_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
            S_MEMWRITE: begin mreq = 1'b1; asrc = 1'b1; mw = 1'b1; end
            S_EXECR:    begin sa = 2'b10; aop = 2'b10; end
            S_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            S_ALUWB:    rw = 1'b1;
            S_BRANCH:   begin sa = 2'b10; aop = 2'b01; br = 1'b1; end
            S_JAL:      begin sa = 2'b01; sb = 2'b10; pcu = 1'b1; end
            S_UPPER:    begin rw = 1'b1; rs = (o == OP_LUI) ? 2'b11 : 2'b00; end
            S_TRAP:     ill = 1'b1;
            S_ERR:      be = 1'b1;
            default:    ;
        endcase
        case (o)
            OP_STORE:         imm = 3'b001;
            OP_BR:            imm = 3'b010;
            OP_JAL:           imm = 3'b011;
            OP_LUI, OP_AUIPC: imm = 3'b100;
            default:          imm = 3'b000;
        endcase
        return {st, mreq, asrc, irw, pcu, mw, rw, br, sa, sb, aop, rs, imm, be, ill, exp_instret};
    endfunction

    task automatic check_out();
        logic [W-1:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        assert (w_obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, w_obs, e);
        end
    endtask

    task automatic check_zero();
        exp_q.push_back('0);
        check_out();
    endtask

    // driver: one cycle in state st with the given mem_ready, then advance to the next falling edge
    task automatic step(input logic [3:0] st, input logic mr);
        mem_ready = mr;
`ifndef MULTICYCLE_TRAP_EN
        trap_ack = rnd();
`endif
        exp_q.push_back(exp_vec(st, op, mr));
        #1;
        check_out();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_zero();
        @(negedge clk);
        #1;
        check_zero();
        rst_n       = 1'b1;
        exp_instret = '0;
    endtask

    task automatic do_instr(input logic [6:0] o, input int fstall, input int mstall);
        logic retire;
        retire = 1'b1;
        op = o;
        for (int i = 0; i < fstall; i++) step(S_FETCH, 1'b0);
        step(S_FETCH, 1'b1);
        step(S_DECODE, rnd());
        case (o)
            OP_LOAD: begin
                step(S_MEMADR, rnd());
                for (int i = 0; i < mstall; i++) step(S_MEMREAD, 1'b0);
                step(S_MEMREAD, 1'b1);
                step(S_MEMWB, rnd());
            end
            OP_STORE: begin
                step(S_MEMADR, rnd());
                for (int i = 0; i < mstall; i++) step(S_MEMWRITE, 1'b0);
                step(S_MEMWRITE, 1'b1);
            end
            OP_R:             begin step(S_EXECR, rnd()); step(S_ALUWB, rnd()); end
            OP_I:             begin step(S_EXECI, rnd()); step(S_ALUWB, rnd()); end
            OP_BR:            step(S_BRANCH, rnd());
            OP_JAL:           begin step(S_JAL, rnd()); step(S_ALUWB, rnd()); end
            OP_LUI, OP_AUIPC: step(S_UPPER, rnd());
            default: begin
`ifdef MULTICYCLE_TRAP_EN
                retire   = 1'b0;
                trap_ack = 1'b0;
                step(S_TRAP, rnd());
                step(S_TRAP, rnd());
                trap_ack = 1'b1;
                step(S_TRAP, rnd());
                trap_ack = 1'b0;
`endif
            end
        endcase
        if (retire) exp_instret = exp_instret + 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        op          = '0;
        mem_ready   = 1'b0;
        trap_ack    = 1'b0;
        exp_instret = '0;

        tag = "reset";
        do_reset();

        tag = "r_type";       do_instr(OP_R, 0, 0);
        tag = "i_type_fstall"; do_instr(OP_I, 2, 0);
        tag = "load_3stall";  do_instr(OP_LOAD, 0, 3);
        tag = "store_1stall"; do_instr(OP_STORE, 0, 1);
        tag = "branch";       do_instr(OP_BR, 0, 0);
        tag = "jal";          do_instr(OP_JAL, 0, 0);
        tag = "lui";          do_instr(OP_LUI, 0, 0);
        tag = "auipc";        do_instr(OP_AUIPC, 0, 0);
        tag = "max_stall_ok"; do_instr(OP_LOAD, 7, 7);
        tag = "max_stall_st"; do_instr(OP_STORE, 0, 7);
        tag = "illegal_op";   do_instr(OP_BAD, 0, 0);
        tag = "after_illegal"; do_instr(OP_R, 0, 0);

        tag = "wrap_reset";
        do_reset();
        tag = "instret_wrap";
        for (int i = 0; i < 16; i++) do_instr(OP_BR, 0, 0);
        do_instr(OP_R, 0, 0);

        tag = "reset_mid_store";
        op = OP_STORE;
        step(S_FETCH, 1'b1);
        step(S_DECODE, rnd());
        step(S_MEMADR, rnd());
        step(S_MEMWRITE, 1'b0);
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero();
        @(negedge clk);
        #1;
        check_zero();
        rst_n       = 1'b1;
        exp_instret = '0;
        step(S_FETCH, 1'b1);
        step(S_DECODE, rnd());
        step(S_MEMADR, rnd());
        step(S_MEMWRITE, 1'b1);
        exp_instret = exp_instret + 1'b1;
        tag = "after_mid_reset"; do_instr(OP_LUI, 0, 0);

        tag = "fetch_timeout";
        op = OP_R;
        for (int i = 0; i < 8; i++) step(S_FETCH, 1'b0);
        for (int i = 0; i < 4; i++) step(S_ERR, rnd());
        step(S_ERR, 1'b1);
        tag = "err_reset";
        do_reset();
        tag = "recover"; do_instr(OP_R, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
